fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter DEPTH, default 2, range 1..4, meaning number of post-EX stages tracked for forwarding (stage 0 = EX/MEM).
REQ-004 SHALL have parameter NUM_SRC, default 2, range 1..3, meaning source operands per EX instruction.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ex_valid, input, 1, meaning an instruction occupies EX.
REQ-008 SHALL have port ex_reg_wr, input, 1, meaning the EX instruction writes the register file.
REQ-009 SHALL have port ex_wr_addr, input, ADDR_W, meaning the EX destination register.
REQ-010 SHALL have port ex_is_load, input, 1, meaning the EX result comes from data memory.
REQ-011 SHALL have port ex_flush, input, 1, meaning the EX instruction is squashed.
REQ-012 SHALL have port ex_src_addr, input, NUM_SRC*ADDR_W, meaning source registers, src i at bits [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port ex_src_data, input, NUM_SRC*DATA_W, meaning register-file read data per source.
REQ-014 SHALL have port stage_data, input, DEPTH*DATA_W, meaning the write-back value currently held by stage k.
REQ-015 SHALL have port fwd_data, output, NUM_SRC*DATA_W, meaning the selected ALU operand per source.
REQ-016 SHALL have port fwd_sel, output, NUM_SRC*3, meaning per source 0 = register file, k+1 = stage k.
REQ-017 SHALL have port stall, output, 1, meaning EX must hold this cycle.
REQ-018 SHALL have port stall_cnt, output, 32, meaning the stall-cycle count.

Function
REQ-019 SHALL keep a DEPTH-entry tag pipeline; each tag holds {valid, reg_wr, addr, is_load}.
REQ-020 SHALL, each cycle, shift tag[k] into tag[k+1] and drop tag[DEPTH-1].
REQ-021 SHALL load tag[0] from the EX inputs when ex_valid=1, stall=0, and ex_flush=0; otherwise tag[0] SHALL become a bubble (valid=0).
REQ-022 SHALL treat tag k as matching source i when valid, reg_wr, addr==src i, and addr!=0.
REQ-023 SHALL select, per source, the matching tag with lowest k; otherwise ex_src_data; fwd_data/fwd_sel SHALL be combinational with zero latency.
REQ-024 SHALL assert stall combinationally when ex_valid=1, ex_flush=0, and any source's lowest-k match is tag[0] with is_load=1 (load-use).
REQ-025 SHALL result in exactly one stall cycle per load-use, because the bubble moves the load to tag[1] and forwarding then selects stage 1.
REQ-026 SHALL, when DEPTH=1, treat a load-use as unresolvable: stall one cycle, then select ex_src_data.
REQ-027 SHALL deassert stall whenever ex_flush=1; flush takes priority over stall.
REQ-028 SHALL drive fwd_data to the ex_src_data value when ex_valid=0; stall SHALL be 0 in that case.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, clear all tags to valid=0 and clear stall_cnt to 0.
REQ-030 SHALL make reset take priority over shift, stall, and flush; the first post-reset cycle SHALL show stall=0 and fwd_sel=0 for all sources.

Configuration
REQ-031 SHALL, with FWD_STALL_CNT_EN defined, increment stall_cnt once per cycle with stall=1, saturating at 0xFFFFFFFF.
REQ-032 SHALL, without FWD_STALL_CNT_EN, omit the counter register and tie stall_cnt to 0; the port list SHALL be unchanged.

Structure
REQ-033 SHALL place the tag typedef, the fwd_sel width constant, and the FWD_SEL_REGFILE=0 constant in shared package fwd_pkg.
REQ-034 SHALL implement the tag shift register as sub-module fwd_tag_pipe (ports: clk, reset, in_tag, in_bubble, tags); match/select logic SHALL stay in the top.

Verification
REQ-035 SHALL cover ALU back-to-back: add r3 in EX, then src0=r3 next cycle with stage_data[0]=0x11 -> fwd_sel0=1, fwd_data0=0x11, stall=0.
REQ-036 SHALL cover load-use: lw r5, then src1=r5 -> stall=1 for exactly one cycle, then fwd_sel1=2 and fwd_data1=stage_data[1]=0xABCD.
REQ-037 SHALL cover priority: r7 in tag[0]=0x1 and tag[1]=0x2 -> fwd_data0=0x1; a write to r0 -> never forwarded, fwd_sel=0.
REQ-038 SHALL cover flush during load-use: ex_flush=1 -> stall=0, tag[0] bubble next cycle, stall_cnt unchanged.
REQ-039 SHALL cover reset mid-stall: reset=1 while stall=1 -> next cycle all tags invalid, stall=0, stall_cnt=0.
REQ-040 SHALL cover the counter with FWD_STALL_CNT_EN: 3 load-use events give stall_cnt=3; a preload of 0xFFFFFFFF plus a stall stays at 0xFFFFFFFF; without the macro, stall_cnt=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// The tag address field is sized for the widest supported register address.
package fwd_pkg;

    localparam int TAG_ADDR_W      = 8;
    localparam int FWD_SEL_W       = 3;
    localparam logic [FWD_SEL_W-1:0] FWD_SEL_REGFILE = 3'd0;

    typedef struct packed {
        logic                  valid;
        logic                  reg_wr;
        logic [TAG_ADDR_W-1:0] addr;
        logic                  is_load;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_tag_pipe.sv
// DEPTH-entry shift register of destination tags for instructions past EX.
// Entry 0 is the EX/MEM stage; the oldest entry falls off the end each cycle.
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  tag_t               in_tag,
    input  logic               in_bubble,
    output tag_t [DEPTH-1:0]   tags
);

    // NOTE: sequential state uses non-blocking assignments so every entry
    // shifts from its pre-edge neighbour, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                tags[k] <= TAG_BUBBLE;
            end
        end else begin
            tags[0] <= in_bubble ? TAG_BUBBLE : in_tag;
            for (int k = 1; k < DEPTH; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall detection for the EX stage.
// Optional build macro FWD_STALL_CNT_EN enables the saturating stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 2,
    parameter int NUM_SRC = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ex_valid,
    input  logic                        ex_reg_wr,
    input  logic [ADDR_W-1:0]           ex_wr_addr,
    input  logic                        ex_is_load,
    input  logic                        ex_flush,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   ex_src_data,
    input  logic [DEPTH*DATA_W-1:0]     stage_data,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel,
    output logic                        stall,
    output logic [31:0]                 stall_cnt
);

    tag_t [DEPTH-1:0] tags;
    tag_t             in_tag;
    logic             in_bubble;
    logic [NUM_SRC-1:0] load_use;

    always_comb begin
        in_tag         = TAG_BUBBLE;
        in_tag.valid   = 1'b1;
        in_tag.reg_wr  = ex_reg_wr;
        in_tag.addr    = TAG_ADDR_W'(ex_wr_addr);
        in_tag.is_load = ex_is_load;
    end

    // A stalled or squashed EX instruction must not appear downstream.
    assign in_bubble = !ex_valid || stall || ex_flush;

    fwd_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_tag    (in_tag),
        .in_bubble (in_bubble),
        .tags      (tags)
    );

    // Scan oldest-to-youngest so the youngest (lowest k) match wins.
    always_comb begin
        logic [TAG_ADDR_W-1:0] src;
        fwd_data = ex_src_data;
        fwd_sel  = '0;
        load_use = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = TAG_ADDR_W'(ex_src_addr[i*ADDR_W +: ADDR_W]);
            fwd_sel[i*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_REGFILE;
            load_use[i] = 1'b0;
            if (ex_valid) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (tags[k].valid && tags[k].reg_wr &&
                        tags[k].addr == src && src != '0) begin
                        fwd_sel[i*FWD_SEL_W +: FWD_SEL_W]  = FWD_SEL_W'(k + 1);
                        fwd_data[i*DATA_W +: DATA_W]       = stage_data[k*DATA_W +: DATA_W];
                        load_use[i] = (k == 0) && tags[k].is_load;
                    end
                end
            end
        end
    end

    assign stall = ex_valid && !ex_flush && (|load_use);

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (DEPTH=2, NUM_SRC=2).
// Counter expectations follow the FWD_STALL_CNT_EN build macro.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 2;
    localparam int NUM_SRC = 2;

`ifdef FWD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [DATA_W-1:0] RF0 = 32'hAAAA_0000;
    localparam logic [DATA_W-1:0] RF1 = 32'hBBBB_0001;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          ex_valid;
    logic                          ex_reg_wr;
    logic [ADDR_W-1:0]             ex_wr_addr;
    logic                          ex_is_load;
    logic                          ex_flush;
    logic [NUM_SRC*ADDR_W-1:0]     ex_src_addr;
    logic [NUM_SRC*DATA_W-1:0]     ex_src_data;
    logic [DEPTH*DATA_W-1:0]       stage_data;
    logic [NUM_SRC*DATA_W-1:0]     fwd_data;
    logic [NUM_SRC*FWD_SEL_W-1:0]  fwd_sel;
    logic                          stall;
    logic [31:0]                   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_reg_wr   (ex_reg_wr),
        .ex_wr_addr  (ex_wr_addr),
        .ex_is_load  (ex_is_load),
        .ex_flush    (ex_flush),
        .ex_src_addr (ex_src_addr),
        .ex_src_data (ex_src_data),
        .stage_data  (stage_data),
        .fwd_data    (fwd_data),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [ADDR_W-1:0] wa,
                         input logic ld, input logic fl,
                         input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1);
        ex_valid    = v;
        ex_reg_wr   = wr;
        ex_wr_addr  = wa;
        ex_is_load  = ld;
        ex_flush    = fl;
        ex_src_addr = {s1, s0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] d(input int i);
        return fwd_data[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [FWD_SEL_W-1:0] s(input int i);
        return fwd_sel[i*FWD_SEL_W +: FWD_SEL_W];
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset       = 1'b1;
        ex_src_data = {RF1, RF0};
        stage_data  = '0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;

        // First post-reset cycle: issue add r3 with unrelated sources.
        drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd3, 5'd3);
        check("post_reset_stall", 64'(stall), 64'd0);
        check("post_reset_sel", 64'(fwd_sel), 64'd0);
        check("post_reset_data0", 64'(d(0)), 64'(RF0));
        check("post_reset_cnt", 64'(stall_cnt), 64'd0);
        tick();

        // ALU back-to-back: src0=r3 forwards from stage 0.
        stage_data = {32'h0000_0022, 32'h0000_0011};
        drive(1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd3, 5'd4);
        check("alu_b2b_sel0", 64'(s(0)), 64'd1);
        check("alu_b2b_data0", 64'(d(0)), 64'h11);
        check("alu_b2b_sel1", 64'(s(1)), 64'd0);
        check("alu_b2b_data1", 64'(d(1)), 64'(RF1));
        check("alu_b2b_stall", 64'(stall), 64'd0);
        tick();

        // r3 now in stage 1; EX issues lw r5.
        drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd3, 5'd0);
        check("stage1_sel0", 64'(s(0)), 64'd2);
        check("stage1_data0", 64'(d(0)), 64'h22);
        check("stage1_stall", 64'(stall), 64'd0);
        tick();

        // Load-use on src1=r5: one stall, then forward from stage 1.
        stage_data = {32'h0000_ABCD, 32'h0000_0011};
        drive(1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd1, 5'd5);
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_release_stall", 64'(stall), 64'd0);
        check("lu_sel1", 64'(s(1)), 64'd2);
        check("lu_data1", 64'(d(1)), 64'hABCD);
        check("lu_sel0", 64'(s(0)), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'(cnt_exp(1)));
        tick();

        // Two writes to r7 back to back, then read r7 while writing r0.
        drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd1, 5'd2);
        tick();
        drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd1, 5'd2);
        tick();
        stage_data = {32'h0000_0002, 32'h0000_0001};
        drive(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0);
        check("prio_sel0", 64'(s(0)), 64'd1);
        check("prio_data0", 64'(d(0)), 64'h1);
        tick();

        // r0 write sits in tag 0: never forwarded. EX issues lw r9.
        drive(1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
        check("r0_sel", 64'(fwd_sel), 64'd0);
        check("r0_data0", 64'(d(0)), 64'(RF0));
        tick();

        // Flush while load-use is pending: no stall, tag 0 becomes a bubble.
        stage_data = {32'h0000_9999, 32'h0000_5555};
        drive(1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 5'd9, 5'd0);
        check("flush_stall", 64'(stall), 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        check("idle_data0", 64'(d(0)), 64'(RF0));
        check("idle_stall", 64'(stall), 64'd0);
        drive(1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 5'd0);
        check("flush_bubble_sel0", 64'(s(0)), 64'd2);
        check("flush_bubble_data0", 64'(d(0)), 64'h9999);
        check("flush_bubble_stall", 64'(stall), 64'd0);
        check("flush_cnt", 64'(stall_cnt), 64'(cnt_exp(1)));
        tick();

        // Reset mid-stall.
        drive(1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 5'd10, 5'd0);
        check("pre_reset_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_sel", 64'(fwd_sel), 64'd0);
        check("reset_cnt", 64'(stall_cnt), 64'd0);

        // Three load-use events.
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0);
            tick();
            drive(1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 5'd12, 5'd0);
            check("ev_stall", 64'(stall), 64'd1);
            tick();
            check("ev_nostall", 64'(stall), 64'd0);
            tick();
        end
        check("three_ev_cnt", 64'(stall_cnt), 64'(cnt_exp(3)));

`ifdef FWD_STALL_CNT_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        drive(1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 5'd0, 5'd14);
        check("sat_stall", 64'(stall), 64'd1);
        tick();
        check("sat_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
